pacman_sprite_fetch: RTL

Per-pixel sprite fetch and animation stage for the Pac-Man player. It sits between the VGA scan counter and the colour mapper. It tracks the mouth-animation frame, forms the address into the concatenated Pac-Man frame ROM and aligns the returned 1-bit palette index to the scan pipeline. It then resolves index to 12-bit RGB using the per-frame palette polarity, emitting a hit flag for the colour mapper's priority mux.

---
 rtl/pacman_pkg.sv | 36 +++
 rtl/pacman_frame_color.sv | 28 ++
 rtl/pacman_sprite_fetch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite path: direction/animation
// encodings, body colours, per-frame body polarity and the pipeline tag.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        F0 = 2'd0,
        F1 = 2'd1,
        F2 = 2'd2
    } anim_t;

    localparam logic [11:0] PAC_YELLOW = 12'hFF0;
    localparam logic [11:0] PAC_FREEZE = 12'h6CF;

    // Bit n set: body pixels of frame n are stored as index 1 (frames 0,3,5,6,7,8,9).
    localparam logic [11:0] BODY_IS_ONE = 12'h3E9;
    localparam int unsigned NUM_FRAMES = 12;

    // Per-pixel side information that travels alongside the ROM access.
    typedef struct packed {
        logic       in_box;
        logic       freeze;
        logic [3:0] frame_id;
    } pix_tag_t;

    function automatic logic [3:0] frame_id_of(input dir_t d, input anim_t s);
        return ({2'b00, d} * 4'd3) + {2'b00, s};
    endfunction

endpackage

// File: rtl/pacman_frame_color.sv
// Resolves the ROM palette index of one pixel to hit flag and 12-bit RGB using
// the body polarity of the frame it was fetched from.
module pacman_frame_color
    import pacman_pkg::*;
(
    input  logic [3:0]  frame_id,
    input  logic        in_box,
    input  logic        index,
    input  logic        freeze,
    output logic        hit,
    output logic [11:0] rgb
);

    logic body_one;

    always_comb begin
        body_one = 1'b0;
        if (frame_id < 4'(NUM_FRAMES)) begin
            body_one = BODY_IS_ONE[frame_id];
        end
        hit = in_box && (index == body_one);
        rgb = 12'h000;
        if (hit) begin
            rgb = freeze ? PAC_FREEZE : PAC_YELLOW;
        end
    end

endmodule

// File: rtl/pacman_sprite_fetch.sv
// Pac-Man sprite fetch: frame-latched position/direction, mouth animation, ROM
// addressing and colour resolve. Optional PAC_FREEZE_EN enables freeze colouring.
module pacman_sprite_fetch
    import pacman_pkg::*;
#(
    parameter int unsigned SPR_SIZE = 16,
    parameter int unsigned ANIM_DIV = 4,
    parameter int unsigned ROM_LAT  = 1   // must be >= 1
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           frame_start,
    input  logic [9:0]                     DrawX,
    input  logic [9:0]                     DrawY,
    input  logic [9:0]                     pac_x,
    input  logic [9:0]                     pac_y,
    input  logic [1:0]                     dir,
    input  logic                           moving,
    input  logic                           freeze,
    output logic [2*$clog2(SPR_SIZE)+3:0]  rom_addr,
    input  logic                           rom_index,
    output logic                           pix_hit,
    output logic [11:0]                    pix_rgb
);

    localparam int unsigned CW = $clog2(SPR_SIZE);
    localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [10:0]   SPAN     = 11'(SPR_SIZE);
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    logic [9:0] px_q, py_q;
    dir_t       dir_q;
    logic       frz_cur;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            px_q  <= '0;
            py_q  <= '0;
            dir_q <= DIR_RIGHT;
        end else if (frame_start) begin
            px_q  <= pac_x;
            py_q  <= pac_y;
            dir_q <= dir_t'(dir);
        end
    end

`ifdef PAC_FREEZE_EN
    logic freeze_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            freeze_q <= 1'b0;
        end else if (frame_start) begin
            freeze_q <= freeze;
        end
    end

    assign frz_cur = freeze_q;
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
    assign frz_cur       = 1'b0;
`endif

    // Mouth animation: ping-pong F0->F1->F2->F1->F0, one step per ANIM_DIV moving frames.
    anim_t         state_q, state_d;
    logic          up_q, up_d;
    logic [DW-1:0] div_q, div_d;

    always_comb begin
        state_d = state_q;
        up_d    = up_q;
        div_d   = div_q;
        if (frame_start && moving) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                case (state_q)
                    F0: begin
                        state_d = F1;
                        up_d    = 1'b1;
                    end
                    F1:      state_d = up_q ? F2 : F0;
                    F2: begin
                        state_d = F1;
                        up_d    = 1'b0;
                    end
                    default: state_d = F0;
                endcase
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= F0;
            up_q    <= 1'b1;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            div_q   <= div_d;
        end
    end

    // Stage 0: hit test. The extra borrow bit rejects pixels left/above the
    // sprite origin, so a sprite hanging off the left or top edge is clipped.
    logic [10:0]  dx, dy;
    logic         in_box0;
    logic [3:0]   frame_id0;
    pix_tag_t     tag0;

    always_comb begin
        dx        = {1'b0, DrawX} - {1'b0, px_q};
        dy        = {1'b0, DrawY} - {1'b0, py_q};
        in_box0   = (dx < SPAN) && (dy < SPAN);
        frame_id0 = frame_id_of(dir_q, state_q);
        tag0      = '{in_box: in_box0, freeze: frz_cur, frame_id: frame_id0};
    end

    // pipe[0] is S1 (alongside rom_addr); pipe[ROM_LAT] lines up with rom_index.
    pix_tag_t [ROM_LAT:0] pipe;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            pipe     <= '0;
        end else begin
            rom_addr <= {frame_id0, dy[CW-1:0], dx[CW-1:0]};
            pipe     <= {pipe[ROM_LAT-1:0], tag0};
        end
    end

    logic        hit_c;
    logic [11:0] rgb_c;

    pacman_frame_color u_color (
        .frame_id (pipe[ROM_LAT].frame_id),
        .in_box   (pipe[ROM_LAT].in_box),
        .index    (rom_index),
        .freeze   (pipe[ROM_LAT].freeze),
        .hit      (hit_c),
        .rgb      (rgb_c)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_hit <= 1'b0;
            pix_rgb <= '0;
        end else begin
            pix_hit <= hit_c;
            pix_rgb <= rgb_c;
        end
    end

endmodule
